// File: rtl/cpsr_cond_stage.sv
// cpsr_cond_stage: execute-commit stage behind the 32-bit ALU.
// Holds the architectural NZCV flags and evaluates ARM condition codes
// against them. Commits ALU flags on S-bit or compare instructions, and
// emits surviving results through a one-entry valid/ready buffer.
module cpsr_cond_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [3:0]       opcode,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_flags,
  input  logic             shifter_carry,
  input  logic [3:0]       rd,
  input  logic             write_en,
  output logic             carry_to_alu,
  output logic [3:0]       nzcv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        we;
  } wb_t;

  wb_t  buf_q;
  logic pass, accept, emit, squash, upd;
  logic cmp_cls, logic_cls;
  logic fn, fz, fc, fv;
  logic [3:0] nzcv_nxt;

  assign {fn, fz, fc, fv} = nzcv;

  // The buffer can take a new entry when it is empty or draining this cycle.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign emit     = accept & pass;
  assign squash   = accept & !pass;

  // TST/TEQ/CMP/CMN occupy 8..B; logical ops take C from the shifter.
  assign cmp_cls   = (opcode[3:2] == 2'b10);
  assign logic_cls = (opcode[3:1] == 3'b000) | (opcode[3:2] == 2'b11) |
                     (opcode[3:1] == 3'b100);
  assign upd       = emit & (set_flags | cmp_cls);

  // Condition evaluation on the committed flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc & !fz;
      4'h9: pass = !fc | fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = !fz & (fn == fv);
      4'hD: pass = fz | (fn != fv);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // Next flag value: N/Z always from the ALU; C/V depend on op class.
  always_comb begin
    nzcv_nxt[3:2] = alu_flags[3:2];
    nzcv_nxt[1]   = logic_cls ? shifter_carry : alu_flags[1];
    nzcv_nxt[0]   = logic_cls ? fv            : alu_flags[0];
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   nzcv <= 4'b0000;
    else if (upd) nzcv <= nzcv_nxt;
  end

  assign carry_to_alu = fc;

  // One-entry output buffer; emit wins over drain so throughput is 1/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      buf_q     <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      buf_q     <= '{result: alu_result, rd: rd, we: write_en & !cmp_cls};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_result = buf_q.result;
  assign out_rd     = buf_q.rd;
  assign out_we     = buf_q.we;

  // Saturating retire/squash counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      squash_cnt <= '0;
    end else begin
      if (emit && retire_cnt != {CNT_W{1'b1}})
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (squash && squash_cnt != {CNT_W{1'b1}})
        squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/cpsr_cond_stage.md
Name: cpsr_cond_stage

Overview:
- Execute-commit stage directly downstream of the 32-bit ALU.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit ARM condition field against it.
- Commits the ALU flags when the instruction requests it, and supplies the committed carry back to the ALU's carry input.
- Registers the surviving result into a one-entry valid/ready output buffer for writeback, and counts retired and squashed instructions.

Parameters:
CNT_W, 16, width of the retire and squash counters (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU output and instruction sideband are valid
in_ready  out  1  stage can accept this cycle
cond  in  4  ARM condition field
set_flags  in  1  S bit
opcode  in  4  ALU opcode, same encoding as the ALU
alu_result  in  32  ALU result c
alu_flags  in  4  ALU flags, [3]=N [2]=Z [1]=C [0]=V
shifter_carry  in  1  barrel-shifter carry-out for logical ops
rd  in  4  destination register index
write_en  in  1  instruction writes rd
carry_to_alu  out  1  committed C flag, drives the ALU carry input
nzcv  out  4  committed flags, same bit order
out_valid  out  1  output buffer holds a retired instruction
out_ready  in  1  writeback accepts
out_result  out  32  registered result
out_rd  out  4  registered destination
out_we  out  1  registered register-file write enable
retire_cnt  out  CNT_W  instructions emitted
squash_cnt  out  CNT_W  condition-failed instructions

Behaviour:
- Reset (async, rst_n=0): nzcv=0, out_valid=0, out_result=0, out_rd=0, out_we=0, retire_cnt=0, squash_cnt=0. All outputs hold these values until the first accept after reset deasserts.
- in_ready = !out_valid | out_ready (combinational). An accept is in_valid & in_ready at a rising edge.
- Condition pass, evaluated combinationally on the current nzcv:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F never-pass (treated as squash).
- Compare class = opcode 8–B (TST, TEQ, CMP, CMN). Logical class = opcodes 0, 1, 8, 9, C, D, E, F.
- Flag update, on an accept with pass & (set_flags | compare class):
  - N and Z always take alu_flags[3:2].
  - Arithmetic ops (2–7, A, B): C and V take alu_flags[1:0].
  - Logical class: C takes shifter_carry; V is preserved.
  - Update takes effect at the accept edge. The next accepted instruction, including one in the following cycle, evaluates its condition against the updated flags, and carry_to_alu reflects them.
  - No flag change occurs on a squash or when no accept happens.
- Emission, on an accept with pass:
  - out_valid<=1, out_result<=alu_result, out_rd<=rd, out_we<=write_en & !compare class.
  - retire_cnt increments.
  - Compare-class instructions are still emitted, with out_we=0, to keep retire ordering.
- Squash, on an accept with !pass:
  - Nothing is emitted; squash_cnt increments.
  - If out_ready drains the buffer in the same cycle, out_valid<=0.
- Output buffer:
  - If out_valid & out_ready with no emitting accept, out_valid<=0.
  - A simultaneous drain and emit replaces the contents back-to-back, giving 1 instruction/cycle throughput.
  - out_result, out_rd and out_we hold stable while out_valid & !out_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-operation drops any buffered instruction and clears the flags immediately (asynchronous).

Test Plan:
- Reset with rst_n=0 mid-stream while out_valid=1 -> out_valid, nzcv and both counters read 0 before the next clk edge.
- CMP (opcode A, cond E) with alu_flags=4'b0110, then next cycle cond 0 (EQ) with alu_result=32'h5, write_en=1 -> nzcv=0110 after the first, second emitted with out_we=1, out_result=5, retire_cnt=2.
- nzcv=0100, cond 1 (NE) instruction -> squashed, no out_valid, squash_cnt=1, nzcv unchanged.
- ORR with S=1, alu_flags=1000, shifter_carry=1, prior nzcv=0001 -> nzcv=1011 (V preserved, C from shifter).
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 while buffered, out_result stable, no counter changes. Then out_ready=1 -> one transfer per cycle, in order.
- Preload retire_cnt near saturation (CNT_W=4), retire 20 instructions -> retire_cnt sticks at 15.
